// File: rtl/counter_pkg.sv
// Shared types and constants for the quadrature decoder slice.
// Build option: QUAD_DECODER_ERR_EN enables the sticky illegal-transition flag.
package counter_pkg;

    typedef logic [1:0] quad_state_t;

    localparam logic        DIR_UP    = 1'b0;
    localparam logic        DIR_DOWN  = 1'b1;
    localparam int unsigned DIV_CNT_W = 27;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_UP,
        MOVE_DOWN,
        MOVE_ILLEGAL
    } quad_move_t;

    // Up order is 00 -> 01 -> 11 -> 10 -> 00; down is the reverse.
    function automatic quad_move_t quad_classify(input quad_state_t prev_s,
                                                 input quad_state_t cur_s);
        quad_move_t mv;
        case ({prev_s, cur_s})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: mv = MOVE_UP;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: mv = MOVE_DOWN;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: mv = MOVE_ILLEGAL;
            default:                            mv = MOVE_NONE;
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Per-channel 2-flop synchronizer followed by a FILT_LEN-deep majority-free
// agreement filter sampled on the shared divider tick.
module quad_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic lvl_o,
    output logic acc_o
);

    localparam logic [3:0] FILL_MAX = 4'(FILT_LEN);

    logic                sync1_q, sync2_q;
    logic [FILT_LEN-1:0] hist_q, hist_d;
    logic [3:0]          fill_q, fill_d;
    logic                lvl_q, lvl_d;
    logic                acc_q, acc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // acc flags an agreement only once the history holds FILT_LEN real samples.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        lvl_d  = lvl_q;
        acc_d  = 1'b0;
        if (tick_i) begin
            hist_d = {hist_q[FILT_LEN-2:0], sync2_q};
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 4'd1;
            end
            if ((hist_d == '0) || (hist_d == '1)) begin
                lvl_d = hist_d[0];
                acc_d = (fill_d == FILL_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            lvl_q  <= 1'b0;
            acc_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            lvl_q  <= lvl_d;
            acc_q  <= acc_d;
        end
    end

    assign lvl_o = lvl_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: sample divider, filtered state tracking and wrap-around counter.
// Build option: define QUAD_DECODER_ERR_EN to implement the sticky err flag.
module quad_decoder
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DIV      = 1250,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [WIDTH-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV - 1);

    typedef enum logic {
        PH_INIT,
        PH_TRACK
    } phase_t;

    logic [DIV_CNT_W-1:0] div_q, div_d;
    logic                 tick;
    logic                 lvl_a, lvl_b, acc_a, acc_b;
    quad_state_t          cur_s;
    quad_state_t          prev_q, prev_d;
    phase_t               phase_q, phase_d;
    quad_move_t           move;
    logic [WIDTH-1:0]     pos_q, pos_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;

    assign tick = enable && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (enable) begin
            div_d = tick ? '0 : div_q + DIV_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .tick_i (tick),
        .raw_i  (enc_a),
        .lvl_o  (lvl_a),
        .acc_o  (acc_a)
    );

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .tick_i (tick),
        .raw_i  (enc_b),
        .lvl_o  (lvl_b),
        .acc_o  (acc_b)
    );

    assign cur_s = {lvl_a, lvl_b};
    assign move  = quad_classify(prev_q, cur_s);

`ifdef QUAD_DECODER_ERR_EN
    logic err_q, err_d;
`endif

    always_comb begin
        phase_d = phase_q;
        prev_d  = prev_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
`ifdef QUAD_DECODER_ERR_EN
        err_d   = err_q;
`endif
        case (phase_q)
            PH_INIT: begin
                // Both channels must hold a fully filled, agreeing history
                // before the first state is trusted as a reference.
                if (acc_a && acc_b) begin
                    prev_d  = cur_s;
                    phase_d = PH_TRACK;
                end
            end
            PH_TRACK: begin
                if (cur_s != prev_q) begin
                    prev_d = cur_s;
                    case (move)
                        MOVE_UP: begin
                            pos_d  = pos_q + WIDTH'(1);
                            dir_d  = DIR_UP;
                            step_d = 1'b1;
                        end
                        MOVE_DOWN: begin
                            pos_d  = pos_q - WIDTH'(1);
                            dir_d  = DIR_DOWN;
                            step_d = 1'b1;
                        end
                        MOVE_ILLEGAL: begin
`ifdef QUAD_DECODER_ERR_EN
                            err_d = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: phase_d = PH_INIT;
        endcase
        // Clear wins over a same-cycle step but leaves dir and tracking intact.
        if (clear) begin
            pos_d  = '0;
            step_d = 1'b0;
`ifdef QUAD_DECODER_ERR_EN
            err_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_INIT;
            prev_q  <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            prev_q  <= prev_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

`ifdef QUAD_DECODER_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign pos  = pos_q;
    assign step = step_q;
    assign dir  = dir_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (WIDTH=4, DIV=4, FILT_LEN=3): directed
// scenarios plus randomized stimulus compared every cycle with a behavioural model.
module tb_quad_decoder;

    localparam int W   = 4;
    localparam int DV  = 4;
    localparam int FL  = 3;
    localparam int MOD = 1 << W;
`ifdef QUAD_DECODER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         clear = 1'b0;
    logic         enc_a = 1'b0;
    logic         enc_b = 1'b0;
    logic [W-1:0] pos;
    logic         step, dir, err;

    int errors = 0;
    int checks = 0;
    int nsteps = 0;
    bit armed = 1'b0;

    quad_decoder #(.WIDTH(W), .DIV(DV), .FILT_LEN(FL)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .pos    (pos),
        .step   (step),
        .dir    (dir),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Gray position of each {a,b} state along the up sequence.
    logic [1:0] gval [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic int gidx(input logic [1:0] s);
        for (int i = 0; i < 4; i++) if (gval[i] == s) return i;
        return 0;
    endfunction

    // ---------------- behavioural model ----------------
    bit         m_ra1 [2];
    bit         m_ra2 [2];
    bit         m_sa [$] = '{0, 0, 0};
    bit         m_sb [$] = '{0, 0, 0};
    bit         m_lvl [2];
    int         m_cnt = 0;
    int         m_ticks = 0;
    bit         m_acc = 0;
    bit         m_init = 0;
    logic [1:0] m_prev = 2'b00;
    int         m_pos = 0;
    bit         m_step = 0, m_dir = 0, m_err = 0;

    function automatic bit all_same(input bit q [$]);
        for (int i = 1; i < q.size(); i++) if (q[i] != q[0]) return 0;
        return 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ra1 = '{0, 0}; m_ra2 = '{0, 0};
            m_sa = '{0, 0, 0}; m_sb = '{0, 0, 0};
            m_lvl = '{0, 0};
            m_cnt = 0; m_ticks = 0; m_acc = 0; m_init = 0; m_prev = 2'b00;
            m_pos = 0; m_step = 0; m_dir = 0; m_err = 0;
        end else begin
            logic [1:0] cur;
            int d;
            bit tk, ag_a, ag_b;
            cur = {m_lvl[0], m_lvl[1]};
            m_step = 0;
            if (!m_init) begin
                if (m_acc) begin m_init = 1; m_prev = cur; end
            end else if (cur != m_prev) begin
                d = (gidx(cur) - gidx(m_prev) + 4) % 4;
                if (d == 1) begin m_pos = (m_pos + 1) % MOD; m_dir = 0; m_step = 1; end
                else if (d == 3) begin m_pos = (m_pos + MOD - 1) % MOD; m_dir = 1; m_step = 1; end
                else if (ERR_EN) m_err = 1;
                m_prev = cur;
            end
            if (clear) begin m_pos = 0; m_err = 0; m_step = 0; end
            tk = enable && (m_cnt == DV - 1);
            if (enable) m_cnt = tk ? 0 : m_cnt + 1;
            m_acc = 0;
            if (tk) begin
                m_sa.push_back(m_ra2[0]); if (m_sa.size() > FL) void'(m_sa.pop_front());
                m_sb.push_back(m_ra2[1]); if (m_sb.size() > FL) void'(m_sb.pop_front());
                if (m_ticks < FL) m_ticks++;
                ag_a = all_same(m_sa);
                ag_b = all_same(m_sb);
                if (ag_a) m_lvl[0] = m_sa[0];
                if (ag_b) m_lvl[1] = m_sb[0];
                m_acc = ag_a && ag_b && (m_ticks >= FL);
            end
            m_ra2 = m_ra1;
            m_ra1 = '{enc_a, enc_b};
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        {enc_a, enc_b} = ab;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    logic [1:0] cur_ab;
    int         base, r, found;

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (armed) begin
                    check("pos", int'(pos), m_pos);
                    check("step", int'(step), int'(m_step));
                    check("dir", int'(dir), int'(m_dir));
                    check("err", int'(err), int'(m_err));
                end
                if (step === 1'b1) nsteps++;
            end
        join_none

        #1 reset = 1'b0;
        #1;
        armed = 1'b1;
        check("rst_pos", int'(pos), 0);
        check("rst_step", int'(step), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_err", int'(err), 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        hold(2'b00, 30);

        // Full up cycle
        base = nsteps;
        hold(2'b01, 20); hold(2'b11, 20); hold(2'b10, 20); hold(2'b00, 40);
        check("up_pos", int'(pos), 4);
        check("up_dir", int'(dir), 0);
        check("up_err", int'(err), 0);
        check("up_steps", nsteps - base, 4);

        // Single down step from zero wraps
        pulse_clear();
        check("clr_pos", int'(pos), 0);
        base = nsteps;
        hold(2'b10, 40);
        check("down_pos", int'(pos), 15);
        check("down_dir", int'(dir), 1);
        check("down_steps", nsteps - base, 1);
        hold(2'b00, 40);
        check("wrap_up_pos", int'(pos), 0);

        // One-tick glitch on a
        base = nsteps;
        hold(2'b10, DV);
        hold(2'b00, 40);
        check("glitch_pos", int'(pos), 0);
        check("glitch_steps", nsteps - base, 0);

        // Two-bit jump
        base = nsteps;
        hold(2'b11, 40);
        check("jump_err", int'(err), int'(ERR_EN));
        check("jump_pos", int'(pos), 0);
        check("jump_steps", nsteps - base, 0);
        pulse_clear();
        check("jclr_err", int'(err), 0);
        check("jclr_pos", int'(pos), 0);
        hold(2'b01, 30); hold(2'b00, 30);
        check("two_down_pos", int'(pos), 14);
        pulse_clear();

        // Enable frozen during a transition
        base = nsteps;
        enable = 1'b0;
        hold(2'b01, 40);
        check("en_low_steps", nsteps - base, 0);
        enable = 1'b1;
        found = 0;
        for (int k = 0; k < 3 * DV + 3 && found == 0; k++) begin
            @(negedge clk);
            if (step === 1'b1) found = 1;
        end
        check("en_resume_step", found, 1);
        hold(2'b01, 20);

        // Reset at pos 9 mid-filtering
        pulse_clear();
        for (int k = 0; k < 9; k++) hold(gval[(k + 2) % 4], 20);
        hold(2'b11, 20);
        check("pre_rst_pos", int'(pos), 9);
        {enc_a, enc_b} = 2'b10;
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pos", int'(pos), 0);
        check("mid_rst_step", int'(step), 0);
        check("mid_rst_dir", int'(dir), 0);
        check("mid_rst_err", int'(err), 0);
        {enc_a, enc_b} = 2'b11;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        base = nsteps;
        hold(2'b11, 60);
        check("post_rst_steps", nsteps - base, 0);
        check("post_rst_err", int'(err), 0);
        check("post_rst_pos", int'(pos), 0);

        // Randomized phase
        cur_ab = 2'b11;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      cur_ab = gval[(gidx(cur_ab) + 1) % 4];
            else if (r < 70) cur_ab = gval[(gidx(cur_ab) + 3) % 4];
            else if (r < 78) cur_ab = gval[(gidx(cur_ab) + 2) % 4];
            else if (r < 86) pulse_clear();
            else if (r < 94) enable = ~enable;
            else begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
                @(negedge clk);
            end
            hold(cur_ab, $urandom_range(1, 24));
        end
        enable = 1'b1;
        hold(cur_ab, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, position counter width in bits.
REQ-002 SHALL have parameter DIV, default 1250, sample-tick period in clk cycles (10 us at 125 MHz), legal range 2 to 2^27-1.
REQ-003 SHALL have parameter FILT_LEN, default 3, number of consecutive equal samples required to accept a level, legal range 2 to 8.
REQ-004 SHALL have port clk  input  1  single system clock; all logic is in this domain.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  when high, the sample divider runs; when low, sampling freezes.
REQ-007 SHALL have port clear  input  1  synchronous clear of pos and err.
REQ-008 SHALL have ports enc_a and enc_b  input  1 each  asynchronous quadrature channels.
REQ-009 SHALL have port pos  output  WIDTH  signed-agnostic position count.
REQ-010 SHALL have port step  output  1  one-cycle pulse per accepted count.
REQ-011 SHALL have port dir  output  1  direction of last accepted step: 0 up, 1 down.
REQ-012 SHALL have port err  output  1  sticky illegal-transition flag.

Function
REQ-013 SHALL pass enc_a and enc_b each through a 2-flop synchronizer before any other use.
REQ-014 SHALL use a 27-bit divider counting while enable=1: tick asserts when count==DIV-1, then the counter returns to 0, giving a period of exactly DIV cycles; the counter holds its value while enable=0.
REQ-015 SHALL shift each synchronized channel into a FILT_LEN-deep history on every tick; the filtered level updates only when all FILT_LEN entries agree, otherwise it holds.
REQ-016 SHALL form state {a_f,b_f}; the up sequence is 00->01->11->10->00 and the down sequence is its reverse.
REQ-017 SHALL, on a single-step up change, set pos<=pos+1, dir<=0, and pulse step for one cycle; on a single-step down change, set pos<=pos-1, dir<=1, and pulse step.
REQ-018 SHALL, on a two-bit change (e.g. 00->11), leave pos and dir unchanged, not pulse step, and set err to 1.
REQ-019 SHALL make pos wrap modulo 2^WIDTH in both directions (max+1 -> 0, 0-1 -> max).
REQ-020 SHALL make clear take priority over a same-cycle step: pos<=0 and err<=0, step is not pulsed, and dir is unchanged.
REQ-021 SHALL, on the first filtered-level acceptance after reset, load the previous-state register without counting or flagging (init phase).
REQ-022 SHALL give a latency from a stable input edge to the step pulse of 2 sync cycles + FILT_LEN ticks + 1 cycle, with jitter of at most one tick.

Reset
REQ-023 SHALL, while reset=0, force pos=0, step=0, dir=0, err=0, divider=0, histories=0, and init phase re-armed.
REQ-024 SHALL discard any in-progress filtering when reset is asserted mid-operation; no partial step may be emitted after release.

Configuration
REQ-025 SHALL, with QUAD_DECODER_ERR_EN defined, implement err as in REQ-018 and REQ-020.
REQ-026 SHALL, without QUAD_DECODER_ERR_EN, tie err to constant 0, build no error register, and still ignore two-bit changes for counting.

Structure
REQ-027 SHALL place the quad_state_t typedef (2-bit), the DIR_UP/DIR_DOWN constants, and the DIV_CNT_W=27 constant in the shared package counter_pkg.
REQ-028 SHALL implement the per-channel synchronizer plus FILT_LEN filter as sub-module quad_filter, instantiated twice; the divider, state tracking and counter live in quad_decoder.

Verification (WIDTH=4, DIV=4, FILT_LEN=3)
REQ-029 SHALL cover: reset release with a=b=0, then drive the up sequence 01,11,10,00 with each level held 20 cycles -> four step pulses, pos=4, dir=0, err=0.
REQ-030 SHALL cover: from pos=0, drive one down step (00->10) -> pos=15, dir=1, one step pulse.
REQ-031 SHALL cover: 1-tick glitch on enc_a (shorter than 3 ticks) -> no filtered change, no step, pos unchanged.
REQ-032 SHALL cover: jump 00->11 with QUAD_DECODER_ERR_EN defined -> err=1, pos unchanged; then clear=1 -> err=0, pos=0. Without the macro -> err stays 0.
REQ-033 SHALL cover: enable=0 during an input transition -> no step while low; after enable=1, step occurs within 3 ticks + 3 cycles.
REQ-034 SHALL cover: assert reset at pos=9 mid-filtering -> all outputs 0 immediately; with inputs held at 11 after release -> no step and no err (init phase).
